// File: rtl/x_dac_pkg.sv
// Shared types and helpers for the unit-element DAC code path.
// Mode encoding and thermometer width derivation.
package x_dac_pkg;

    typedef enum logic [1:0] {
        MODE_THERM = 2'b00,
        MODE_DWA   = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    function automatic int therm_w(input int bin_w);
        return 1 << bin_w;
    endfunction

endpackage

// File: rtl/x_therm_dwa_if.sv
// Code handshake and DAC drive bundle between code source and x_therm_dwa.
// Source is the master; the thermometer stage is the slave.
interface x_therm_dwa_if
    import x_dac_pkg::*;
#(
    parameter int BIN_W = 6
);
    localparam int THERM_W = therm_w(BIN_W);

    logic               i_valid;
    logic               o_ready;
    logic [BIN_W-1:0]   i_bin;
    logic [1:0]         i_mode;
    logic [THERM_W-1:0] o_therm;
    logic [BIN_W-1:0]   o_level;

    modport master (
        output i_valid, i_bin, i_mode,
        input  o_ready, o_therm, o_level
    );

    modport slave (
        input  i_valid, i_bin, i_mode,
        output o_ready, o_therm, o_level
    );
endinterface

// File: rtl/x_therm_rot.sv
// Rotated thermometer: 'level' consecutive ones starting at bit 'ptr',
// wrapping modulo the element count. ptr=0 gives a plain thermometer.
module x_therm_rot
    import x_dac_pkg::*;
#(
    parameter int BIN_W = 6
) (
    input  logic [BIN_W-1:0]           level,
    input  logic [BIN_W-1:0]           ptr,
    output logic [therm_w(BIN_W)-1:0]  therm
);
    localparam int THERM_W = therm_w(BIN_W);

    logic [BIN_W-1:0] off;

    // Distance of element i past ptr wraps naturally in BIN_W bits.
    always_comb begin
        therm = '0;
        off   = '0;
        for (int i = 0; i < THERM_W; i++) begin
            off      = BIN_W'(i) - ptr;
            therm[i] = (off < level);
        end
    end
endmodule

// File: rtl/x_therm_dwa.sv
// Binary-to-thermometer DAC driver with slew limit, prescaled update tick
// and optional data-weighted-averaging rotation.
module x_therm_dwa
    import x_dac_pkg::*;
#(
    parameter int BIN_W = 6,
    parameter int STEP  = 4,
    parameter int DIV   = 16
) (
    input logic          i_clk,
    input logic          i_nrst,
    x_therm_dwa_if.slave bus
);
    localparam int THERM_W = therm_w(BIN_W);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0]      cnt;
    logic [BIN_W-1:0]   target;
    logic [BIN_W-1:0]   level;
    logic [BIN_W-1:0]   ptr;
    logic [THERM_W-1:0] therm;
    logic               ready;
    mode_t              last_mode;

    mode_t              mode;
    logic               tick;
    logic               accept;
    logic               run;
    logic               dwa;
    logic [BIN_W-1:0]   up;
    logic [BIN_W-1:0]   dn;
    logic [BIN_W-1:0]   level_nxt;
    logic [BIN_W-1:0]   level_new;
    logic [BIN_W-1:0]   target_nxt;
    logic [BIN_W-1:0]   ptr_base;
    logic [BIN_W-1:0]   rot_ptr;
    logic [THERM_W-1:0] rot;

    assign mode   = mode_t'(bus.i_mode);
    assign tick   = (cnt == CNT_MAX);
    assign accept = bus.i_valid & ready;
    assign run    = tick && (mode != MODE_HOLD);
    assign dwa    = (mode == MODE_DWA);
    assign up     = target - level;
    assign dn     = level - target;

    always_comb begin
        level_nxt = level;
        if (STEP == 0) begin
            level_nxt = target;
        end else if (target > level) begin
            if (int'(up) > STEP) level_nxt = level + BIN_W'(STEP);
            else                 level_nxt = target;
        end else if (level > target) begin
            if (int'(dn) > STEP) level_nxt = level - BIN_W'(STEP);
            else                 level_nxt = target;
        end
    end

    // Re-entering DWA restarts the rotation from element 0.
    assign ptr_base   = (dwa && last_mode != MODE_DWA) ? '0 : ptr;
    assign rot_ptr    = dwa ? ptr_base : '0;
    assign level_new  = run ? level_nxt : level;
    assign target_nxt = accept ? bus.i_bin : target;

    x_therm_rot #(.BIN_W(BIN_W)) u_rot (
        .level (level_nxt),
        .ptr   (rot_ptr),
        .therm (rot)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            cnt       <= '0;
            target    <= '0;
            level     <= '0;
            ptr       <= '0;
            therm     <= '0;
            ready     <= 1'b1;
            last_mode <= MODE_THERM;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            target <= target_nxt;
            ready  <= (level_new == target_nxt);
            if (tick) last_mode <= mode;
            if (run) begin
                level <= level_nxt;
                therm <= rot;
                if (dwa) ptr <= ptr_base + level_nxt;
            end
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_therm = therm;
    assign bus.o_level = level;
endmodule

// File: tb/tb_x_therm_dwa.sv
// Bench for x_therm_dwa: three builds checked against a behavioural model.
module tb_x_therm_dwa;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] bin = '0;
    logic [1:0] mode = 2'b00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    x_therm_dwa_if #(.BIN_W(6)) ifa ();
    x_therm_dwa_if #(.BIN_W(6)) ifb ();
    x_therm_dwa_if #(.BIN_W(6)) ifc ();

    assign ifa.i_valid = valid;
    assign ifa.i_bin   = bin;
    assign ifa.i_mode  = mode;
    assign ifb.i_valid = valid;
    assign ifb.i_bin   = bin;
    assign ifb.i_mode  = mode;
    assign ifc.i_valid = valid;
    assign ifc.i_bin   = bin;
    assign ifc.i_mode  = mode;

    x_therm_dwa #(.BIN_W(6), .STEP(4), .DIV(4)) dut_a (
        .i_clk(clk), .i_nrst(nrst), .bus(ifa.slave));
    x_therm_dwa #(.BIN_W(6), .STEP(0), .DIV(4)) dut_b (
        .i_clk(clk), .i_nrst(nrst), .bus(ifb.slave));
    x_therm_dwa #(.BIN_W(6), .STEP(4), .DIV(1)) dut_c (
        .i_clk(clk), .i_nrst(nrst), .bus(ifc.slave));

    localparam int DV  [3] = '{4, 4, 1};
    localparam int STP [3] = '{4, 0, 4};

    logic [63:0] d_therm [3];
    logic [5:0]  d_level [3];
    logic        d_ready [3];
    assign d_therm[0] = ifa.o_therm;
    assign d_therm[1] = ifb.o_therm;
    assign d_therm[2] = ifc.o_therm;
    assign d_level[0] = ifa.o_level;
    assign d_level[1] = ifb.o_level;
    assign d_level[2] = ifc.o_level;
    assign d_ready[0] = ifa.o_ready;
    assign d_ready[1] = ifb.o_ready;
    assign d_ready[2] = ifc.o_ready;

    // Behavioural model state, one slot per build.
    int          m_cnt [3];
    int          m_target [3];
    int          m_level [3];
    int          m_ptr [3];
    int          m_prev [3];
    logic [63:0] m_therm [3];
    bit          m_ready [3];
    bit          m_tk [3];
    bit          m_init = 0;

    logic [63:0] q_thm0 [$];
    int          q_lvl0 [$];
    int          q_lvl1 [$];

    function automatic logic [63:0] build(input int n, input int p);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[(p + k) % 64] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            int md, d, nl;
            bit tk, acc;
            if (!nrst) begin
                m_cnt[j] = 0; m_target[j] = 0; m_level[j] = 0;
                m_ptr[j] = 0; m_prev[j] = 0; m_therm[j] = '0;
                m_ready[j] = 1; m_tk[j] = 0;
            end else begin
                tk  = (m_cnt[j] == DV[j] - 1);
                acc = valid && m_ready[j];
                md  = (mode == 2'b11) ? 0 : int'(mode);
                if (tk && md != 2) begin
                    d = m_target[j] - m_level[j];
                    if (STP[j] == 0) nl = m_target[j];
                    else if (d > 0) nl = m_level[j] + ((d < STP[j]) ? d : STP[j]);
                    else nl = m_level[j] - ((-d < STP[j]) ? -d : STP[j]);
                    if (md == 1) begin
                        if (m_prev[j] != 1) m_ptr[j] = 0;
                        m_therm[j] = build(nl, m_ptr[j]);
                        m_ptr[j] = (m_ptr[j] + nl) % 64;
                    end else begin
                        m_therm[j] = build(nl, 0);
                    end
                    m_level[j] = nl;
                end
                if (tk) m_prev[j] = md;
                if (acc) m_target[j] = int'(bin);
                m_ready[j] = (m_level[j] == m_target[j]);
                m_cnt[j] = tk ? 0 : m_cnt[j] + 1;
                m_tk[j] = tk;
            end
        end
        if (!nrst) m_init = 1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("therm%0d", j), d_therm[j], m_therm[j]);
                chk($sformatf("level%0d", j), 64'(d_level[j]), 64'(m_level[j]));
                chk($sformatf("ready%0d", j), 64'(d_ready[j]), 64'(m_ready[j]));
            end
            if (m_tk[0]) begin
                q_lvl0.push_back(int'(ifa.o_level));
                q_thm0.push_back(ifa.o_therm);
            end
            if (m_tk[1]) q_lvl1.push_back(int'(ifb.o_level));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clrq();
        q_lvl0.delete();
        q_thm0.delete();
        q_lvl1.delete();
    endtask

    task automatic wait_q(input int n, input string nm);
        int c = 0;
        while (q_lvl0.size() < n && c < 300) begin
            step();
            c++;
        end
        if (q_lvl0.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout ticks=%0d required=%0d", nm, q_lvl0.size(), n);
        end
    endtask

    task automatic wait_ready(input int lvl, input string nm);
        int c = 0;
        while (!(ifa.o_ready && ifb.o_ready && ifc.o_ready &&
                 int'(ifa.o_level) == lvl) && c < 400) begin
            step();
            c++;
        end
        if (c >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s timeout level=%0d required=%0d", nm, ifa.o_level, lvl);
        end
    endtask

    initial begin
        repeat (3) step();
        chk("rst_therm", ifa.o_therm, 64'h0);
        chk("rst_level", 64'(ifa.o_level), 64'd0);
        chk("rst_ready", 64'(ifa.o_ready), 64'd1);
        nrst = 1'b1;

        // THERM slew to 10; a second code during the slew is held off
        mode = 2'b00; valid = 1'b1; bin = 6'd10;
        step();
        clrq();
        chk("accept_ready_low", 64'(ifa.o_ready), 64'd0);
        bin = 6'd20;
        wait_q(3, "slew10");
        valid = 1'b0;
        chk("slew_l0", 64'(q_lvl0[0]), 64'd4);
        chk("slew_l1", 64'(q_lvl0[1]), 64'd8);
        chk("slew_l2", 64'(q_lvl0[2]), 64'd10);
        chk("slew_therm", q_thm0[2], 64'h3FF);
        chk("settled_ready", 64'(ifa.o_ready), 64'd1);

        // DWA rotation at steady level 10
        mode = 2'b01;
        clrq();
        wait_q(8, "dwa");
        chk("dwa_t1", q_thm0[0], 64'h3FF);
        chk("dwa_t2", q_thm0[1], 64'hFFC00);
        chk("dwa_t7", q_thm0[6], 64'hF00000000000003F);
        chk("dwa_t8", q_thm0[7], 64'hFFC0);

        // Full-scale descent 63 -> 0
        mode = 2'b00; valid = 1'b1; bin = 6'd63;
        wait_ready(63, "rise63");
        bin = 6'd0;
        step();
        valid = 1'b0;
        clrq();
        wait_q(16, "fall0");
        chk("fall_first", 64'(q_lvl0[0]), 64'd59);
        chk("fall_15", 64'(q_lvl0[14]), 64'd3);
        chk("fall_16", 64'(q_lvl0[15]), 64'd0);
        chk("nostep_jump", 64'(q_lvl1[0]), 64'd0);

        // HOLD mid-slew at level 8 with target 20
        wait_ready(0, "zero");
        valid = 1'b1; bin = 6'd20;
        step();
        valid = 1'b0;
        clrq();
        wait_q(2, "to8");
        chk("pre_hold", 64'(q_lvl0[1]), 64'd8);
        mode = 2'b10;
        clrq();
        wait_q(5, "hold");
        chk("hold_l0", 64'(q_lvl0[0]), 64'd8);
        chk("hold_l4", 64'(q_lvl0[4]), 64'd8);
        chk("hold_therm", q_thm0[4], 64'hFF);
        mode = 2'b00;
        clrq();
        wait_q(3, "resume");
        chk("resume_0", 64'(q_lvl0[0]), 64'd12);
        chk("resume_1", 64'(q_lvl0[1]), 64'd16);
        chk("resume_2", 64'(q_lvl0[2]), 64'd20);

        // DIV=1: tick on the accept edge still uses the old target
        wait_ready(20, "div1_settle");
        valid = 1'b1; bin = 6'd40;
        step();
        valid = 1'b0;
        chk("div1_same", 64'(ifc.o_level), 64'd20);
        chk("div1_busy", 64'(ifc.o_ready), 64'd0);
        step();
        chk("div1_next", 64'(ifc.o_level), 64'd24);

        // Reset during a slew
        wait_ready(40, "pre_rst");
        valid = 1'b1; bin = 6'd63;
        step();
        valid = 1'b0;
        clrq();
        wait_q(1, "pre_rst_tick");
        nrst = 1'b0;
        step();
        chk("rst2_therm", ifa.o_therm, 64'h0);
        chk("rst2_level", 64'(ifa.o_level), 64'd0);
        chk("rst2_ready", 64'(ifa.o_ready), 64'd1);
        chk("rst2_therm_c", ifc.o_therm, 64'h0);
        nrst = 1'b1;

        // Randomized traffic, model compare covers every cycle
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (i % 40 == 0) begin
                mode = (r < 45) ? 2'b00 : (r < 85) ? 2'b01 :
                       (r < 95) ? 2'b10 : 2'b11;
            end
            valid = ($urandom_range(0, 3) == 0);
            if (valid) bin = 6'($urandom_range(0, 63));
            nrst = ($urandom_range(0, 299) != 0);
            step();
        end
        nrst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
